vcf_seq_multipole: RTL

- Parametrised successor to the voice filter: a multi-bit, time-multiplexed cascade of POLES one-pole lowpass stages, all sharing one multiplier.
- Cutoff is modulated per sample by envelope (with amount control) and LFO. Resonance is global negative feedback from the last pole.
- A registered output selector picks any pole tap (6/12/18/24 dB at POLES=4).
- Sits per voice between the oscillator mixer and the VCA. Runs at the system clock with a sample-rate valid/ready handshake.

---
 rtl/vcf_seq_multipole_if.sv | 26 ++
 rtl/vcf_seq_multipole.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vcf_seq_multipole_if.sv
`default_nettype none
// ============================================================================
// Module   : vcf_seq_multipole_if
// Brief    : Sample-rate audio handshake bundle for the multipole filter.
// Revision : 1.0
// ============================================================================
interface vcf_seq_multipole_if #(
   parameter int W = 16
);
   logic                SAMPLE_VALID;
   logic                SAMPLE_READY;
   logic signed [W-1:0] AUDIO_IN;
   logic signed [W-1:0] AUDIO_OUT;
   logic                OUT_VALID;

   modport master (
      output SAMPLE_VALID, AUDIO_IN,
      input  SAMPLE_READY, AUDIO_OUT, OUT_VALID
   );

   modport slave (
      input  SAMPLE_VALID, AUDIO_IN,
      output SAMPLE_READY, AUDIO_OUT, OUT_VALID
   );
endinterface
`default_nettype wire

// File: rtl/vcf_seq_multipole.sv
`default_nettype none
// ============================================================================
// Module   : vcf_seq_multipole
// Brief    : Time-multiplexed cascade of one-pole lowpass stages sharing one
//            multiplier, with modulated cutoff and global resonance feedback.
//            Optional macro VCF_SOFTCLIP_EN adds a soft clipper on the
//            feedback-corrected input.
// Revision : 1.0
// ============================================================================
module vcf_seq_multipole #(
   parameter int W     = 16,
   parameter int POLES = 4,
   parameter int GW    = 15
)(
   input  wire logic               clk,
   input  wire logic               rst,
   vcf_seq_multipole_if.slave      bus,
   input  wire logic [6:0]         CUTOFF_CC,
   input  wire logic [6:0]         ENV_AMT_CC,
   input  wire logic [6:0]         RESONANCE_CC,
   input  wire logic [6:0]         POLE_SEL_CC,
   input  wire logic [8:0]         ENVELOPE,
   input  wire logic signed [10:0] LFO,
   output logic                    OVERRUN
);
   localparam int c_IW = (POLES > 1) ? $clog2(POLES) : 1;
   localparam int c_PW = W + 8;
   localparam int c_DW = W + 9;
   localparam logic signed [c_DW-1:0] c_HI = c_DW'(2**(W-1) - 1);
   localparam logic signed [c_DW-1:0] c_LO = c_DW'(-(2**(W-1)));

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FEEDBACK = 2'd1,
      S_POLE     = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_ready;
   logic                r_valid;
   logic                r_overrun;
   logic signed [W-1:0] r_out;
   logic signed [W-1:0] r_in;
   logic [6:0]          r_cutoff;
   logic [6:0]          r_env_amt;
   logic [6:0]          r_res;
   logic [6:0]          r_sel;
   logic [8:0]          r_env;
   logic signed [10:0]  r_lfo;
   logic [GW-1:0]       r_g;
   logic signed [W-1:0] r_x0;
   logic [c_IW-1:0]     r_idx;
   logic signed [W-1:0] r_y [0:POLES-1];

   function automatic logic signed [W-1:0] sat_w(input logic signed [c_DW-1:0] v);
      if (v > c_HI)      return c_HI[W-1:0];
      else if (v < c_LO) return c_LO[W-1:0];
      else               return v[W-1:0];
   endfunction

   // Coefficient: base + envelope depth + LFO, clamped to unsigned Q0.GW
   logic [15:0]        w_env_prod;
   logic signed [17:0] w_graw;
   logic [GW-1:0]      w_g;

   assign w_env_prod = r_env * r_env_amt;
   assign w_graw = $signed({3'b000, r_cutoff, 8'h00})
                 + $signed({3'b000, w_env_prod[15:1]})
                 + $signed({{3{r_lfo[10]}}, r_lfo, 4'h0});

   always_comb begin
      w_g = w_graw[GW-1:0];
      if (w_graw[17])            w_g = '0;
      else if (|w_graw[16:GW])   w_g = '1;
   end

   // Resonance: input minus scaled last-pole output
   logic signed [c_PW-1:0] w_fb_prod;
   logic signed [c_PW-1:0] w_fb;
   logic signed [c_DW-1:0] w_diff;
   logic signed [W-1:0]    w_x0;

   assign w_fb_prod = $signed({1'b0, r_res}) * r_y[POLES-1];
   assign w_fb      = w_fb_prod >>> 5;
   assign w_diff    = {{(c_DW-W){r_in[W-1]}}, r_in}
                    - {{(c_DW-c_PW){w_fb[c_PW-1]}}, w_fb};

`ifdef VCF_SOFTCLIP_EN
   localparam logic [c_DW-1:0] c_H = c_DW'(2**(W-2));
   logic [c_DW-1:0]        w_abs;
   logic [c_DW-1:0]        w_mag;
   logic signed [c_DW-1:0] w_clip;

   always_comb begin
      w_abs  = w_diff[c_DW-1] ? $unsigned(-w_diff) : $unsigned(w_diff);
      w_mag  = w_abs;
      w_clip = w_diff;
      if (w_abs > c_H) begin
         w_mag  = c_H + ((w_abs - c_H) >> 1);
         w_clip = w_diff[c_DW-1] ? -$signed(w_mag) : $signed(w_mag);
      end
      w_x0 = sat_w(w_clip);
   end
`else
   assign w_x0 = sat_w(w_diff);
`endif

   // Shared pole datapath: y += ((x - y) * g) >>> GW
   logic [c_IW-1:0]          w_prev_idx;
   logic signed [W-1:0]      w_x;
   logic signed [W-1:0]      w_ycur;
   logic signed [W:0]        w_d;
   logic signed [W+GW+1:0]   w_prod;
   logic signed [W+1:0]      w_step;
   logic signed [W+1:0]      w_sum;
   logic signed [W-1:0]      w_ynew;

   assign w_prev_idx = (r_idx == '0) ? '0 : r_idx - 1'b1;
   assign w_ycur     = r_y[r_idx];
   assign w_x        = (r_idx == '0) ? r_x0 : r_y[w_prev_idx];
   assign w_d        = {w_x[W-1], w_x} - {w_ycur[W-1], w_ycur};
   assign w_prod     = w_d * $signed({1'b0, r_g});
   assign w_step     = w_prod[W+GW+1:GW];
   assign w_sum      = {{2{w_ycur[W-1]}}, w_ycur} + w_step;
   assign w_ynew     = sat_w({{(c_DW-W-2){w_sum[W+1]}}, w_sum});

   logic [c_IW-1:0] w_tap;
   always_comb begin
      w_tap = c_IW'(POLES - 1);
      if (int'(r_sel[6:5]) < POLES - 1) w_tap = c_IW'(r_sel[6:5]);
   end

   logic w_unused;
   assign w_unused = ^{w_prod[GW-1:0], w_env_prod[0], r_sel[4:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_out     <= '0;
         r_in      <= '0;
         r_cutoff  <= '0;
         r_env_amt <= '0;
         r_res     <= '0;
         r_sel     <= '0;
         r_env     <= '0;
         r_lfo     <= '0;
         r_g       <= '0;
         r_x0      <= '0;
         r_idx     <= '0;
         for (int i = 0; i < POLES; i++) r_y[i] <= '0;
      end else begin
         r_valid <= 1'b0;
         if (bus.SAMPLE_VALID && (r_state != S_IDLE)) r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (bus.SAMPLE_VALID) begin
                  r_in      <= bus.AUDIO_IN;
                  r_cutoff  <= CUTOFF_CC;
                  r_env_amt <= ENV_AMT_CC;
                  r_res     <= RESONANCE_CC;
                  r_sel     <= POLE_SEL_CC;
                  r_env     <= ENVELOPE;
                  r_lfo     <= LFO;
                  r_ready   <= 1'b0;
                  r_state   <= S_FEEDBACK;
               end
            end
            S_FEEDBACK: begin
               r_g     <= w_g;
               r_x0    <= w_x0;
               r_idx   <= '0;
               r_state <= S_POLE;
            end
            S_POLE: begin
               r_y[r_idx] <= w_ynew;
               if (r_idx == c_IW'(POLES - 1)) r_state <= S_DONE;
               else                           r_idx   <= r_idx + 1'b1;
            end
            S_DONE: begin
               r_out   <= r_y[w_tap];
               r_valid <= 1'b1;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.SAMPLE_READY = r_ready;
   assign bus.AUDIO_OUT    = r_out;
   assign bus.OUT_VALID    = r_valid;
   assign OVERRUN          = r_overrun;

endmodule
`default_nettype wire
